// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS pipeline stages: reset vector, NOP encoding,
// opcodes, IF/ID register controls and the J-type target helper.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [1:0] {
        IFID_LOAD  = 2'b00,
        IFID_HOLD  = 2'b01,
        IFID_FLUSH = 2'b10
    } ifid_ctrl_e;

    // J-type target: upper nibble of the J instruction's PC+4, then the index.
    function automatic logic [31:0] jump_target(input logic [3:0] pc_plus4_hi,
                                                input logic [25:0] index);
        return {pc_plus4_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads a fetched instruction, holds it on stall,
// or clears it to a NOP bubble on a redirect.
module if_id_register
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  ifid_ctrl_e  ctrl,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0;
            valid    <= 1'b0;
        end else begin
            case (ctrl)
                IFID_FLUSH: begin
                    instr    <= NOP_INSTR;
                    pc_plus4 <= 32'h0;
                    valid    <= 1'b0;
                end
                IFID_HOLD: ;
                default: begin
                    instr    <= fetch_instr;
                    pc_plus4 <= fetch_pc_plus4;
                    valid    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous-read
// instruction memory and feeds the IF/ID register. No branch delay slot.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    ifid_ctrl_e  ifid_ctrl;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // Redirects outrank stall, and a branch outranks a jump (the jump sits on
    // the wrong path behind the resolving branch).
    always_comb begin
        pc_next   = pc_plus4;
        ifid_ctrl = IFID_LOAD;
        if (branch_taken) begin
            pc_next   = branch_target & WORD_ALIGN_MASK;
            ifid_ctrl = IFID_FLUSH;
        end else if (jump) begin
            pc_next   = jump_target(if_id_pc_plus4[31:28], jump_index);
            ifid_ctrl = IFID_FLUSH;
        end else if (stall) begin
            pc_next   = pc;
            ifid_ctrl = IFID_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    if_id_register u_if_id (
        .clk            (clk),
        .reset          (reset),
        .ctrl           (ifid_ctrl),
        .fetch_instr    (imem_data),
        .fetch_pc_plus4 (pc_plus4),
        .instr          (if_id_instr),
        .pc_plus4       (if_id_pc_plus4),
        .valid          (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: a driver pushes the expected
// post-edge state, a negedge monitor pops and compares it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    // Second instance exercising a reset vector near the top of the address space.
    logic        reset2;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;
    logic [25:0] zero_index = 26'h0;
    logic [31:0] imem_addr2;
    logic [31:0] imem_data2;
    logic [31:0] if_id_instr2;
    logic [31:0] if_id_pc_plus42;
    logic        if_id_valid2;

    int checks = 0;
    int failures = 0;

    // Packed expectation: {imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid}
    logic [96:0] exp_q[$];
    logic [96:0] exp2_q[$];

    always #5 clk = ~clk;

    // Memory model: word i (address 4*i) holds i+1.
    assign imem_data  = (imem_addr  >> 2) + 32'd1;
    assign imem_data2 = (imem_addr2 >> 2) + 32'd1;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_index     (jump_index),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset          (reset2),
        .imem_addr      (imem_addr2),
        .imem_data      (imem_data2),
        .stall          (zero_bit),
        .branch_taken   (zero_bit),
        .branch_target  (zero_word),
        .jump           (zero_bit),
        .jump_index     (zero_index),
        .if_id_instr    (if_id_instr2),
        .if_id_pc_plus4 (if_id_pc_plus42),
        .if_id_valid    (if_id_valid2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [96:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_addr",      imem_addr,              e[96:65]);
            check("if_id_instr",    if_id_instr,            e[64:33]);
            check("if_id_pc_plus4", if_id_pc_plus4,         e[32:1]);
            check("if_id_valid",    {31'h0, if_id_valid},   {31'h0, e[0]});
        end
        if (exp2_q.size() > 0) begin
            e = exp2_q.pop_front();
            check("wrap_imem_addr",      imem_addr2,            e[96:65]);
            check("wrap_if_id_instr",    if_id_instr2,          e[64:33]);
            check("wrap_if_id_pc_plus4", if_id_pc_plus42,       e[32:1]);
            check("wrap_if_id_valid",    {31'h0, if_id_valid2}, {31'h0, e[0]});
        end
    end

    // Drive one cycle of inputs, then record the state expected after the edge.
    task automatic step(input logic rst, input logic stl, input logic br,
                        input logic [31:0] bt, input logic jmp, input logic [25:0] ji,
                        input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_pc4, input logic e_valid);
        reset         = rst;
        stall         = stl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jmp;
        jump_index    = ji;
        @(posedge clk);
        exp_q.push_back({e_addr, e_instr, e_pc4, e_valid});
        #1;
    endtask

    task automatic step_wrap(input logic rst, input logic [31:0] e_addr,
                             input logic [31:0] e_instr, input logic [31:0] e_pc4,
                             input logic e_valid);
        reset2 = rst;
        @(posedge clk);
        exp2_q.push_back({e_addr, e_instr, e_pc4, e_valid});
        #1;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;
        @(posedge clk); #1;

        // Reset, then free-run: words 1, 2, 3, 4
        step(1, 0, 0, 32'h0, 0, 26'h0, 32'h0,  32'h0, 32'h0,  0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h4,  32'h1, 32'h4,  1);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h8,  32'h2, 32'h8,  1);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'hC,  32'h3, 32'hC,  1);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h10, 32'h4, 32'h10, 1);

        // Stall three cycles at PC 0x10, then resume without loss
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 32'h0, 0, 26'h0, 32'h10, 32'h4, 32'h10, 1);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h14, 32'h5, 32'h14, 1);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h18, 32'h6, 32'h18, 1);

        // Misaligned branch to 0x1000_0007 lands on 0x1000_0004
        step(0, 0, 1, 32'h1000_0007, 0, 26'h0, 32'h1000_0004, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h1000_0008, 32'h0400_0002, 32'h1000_0008, 1);

        // Jump with if_id_pc_plus4 = 0x1000_0008, index 0x40
        step(0, 0, 0, 32'h0, 1, 26'h40, 32'h1000_0100, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h1000_0104, 32'h0400_0041, 32'h1000_0104, 1);

        // Branch and jump together: branch wins
        step(0, 0, 1, 32'h200, 1, 26'h3FF, 32'h200, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h204, 32'h81, 32'h204, 1);

        // Branch and jump under stall: redirect still happens
        step(0, 1, 1, 32'h300, 1, 26'h3FF, 32'h300, 32'h0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0, 26'h0, 32'h300, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h304, 32'hC1, 32'h304, 1);

        // Jump alone under stall, upper nibble 0
        step(0, 1, 0, 32'h0, 1, 26'h10, 32'h40, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h44, 32'h11, 32'h44, 1);

        // Reset during stall plus branch
        step(1, 1, 1, 32'h500, 0, 26'h0, 32'h0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0, 26'h0, 32'h4, 32'h1, 32'h4, 1);

        // Wrap-around instance: 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0
        step_wrap(1, 32'hFFFF_FFF8, 32'h0, 32'h0, 0);
        step_wrap(0, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 1);
        step_wrap(0, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1);
        step_wrap(0, 32'h0000_0004, 32'h0000_0001, 32'h0000_0004, 1);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drain_main", exp_q.size(), 32'd0);
        check("drain_wrap", exp2_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
